countdown_timer_ctrl: RTL and testbench

//   Countdown sequencer that drives the seconds[8:0] input of the seven-segment display.

---
 rtl/countdown_timer_ctrl.sv | 150 +++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - two-digit BCD countdown sequencer for the seven-segment seconds field
module countdown_timer_ctrl #(
    parameter int          TICKS_PER_SEC = 1000,
    parameter logic [7:0]  DEFAULT_SECS  = 8'h30
) (
    input  logic       clk_out,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] start_bcd,
    input  logic       cancel,
    input  logic       pause,
    output logic [8:0] seconds,
    output logic       timeout,
    output logic       busy
);

    localparam int              PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_tens;
    logic [3:0]      r_ones;
    logic [3:0]      w_tens_nxt;
    logic [3:0]      w_ones_nxt;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   w_presc_nxt;
    logic            r_timeout;
    logic            w_timeout_nxt;
    logic            r_busy;

    logic [7:0]      w_preset_raw;
    logic [3:0]      w_preset_tens;
    logic [3:0]      w_preset_ones;
    logic            w_tick;
    logic [PW-1:0]   w_presc_inc;

    // Preset selection: zero means "use the default", each digit saturates at 9
    always_comb begin
        w_preset_raw  = (start_bcd == 8'h00) ? DEFAULT_SECS : start_bcd;
        w_preset_tens = (w_preset_raw[7:4] > 4'd9) ? 4'd9 : w_preset_raw[7:4];
        w_preset_ones = (w_preset_raw[3:0] > 4'd9) ? 4'd9 : w_preset_raw[3:0];
        w_tick        = (r_presc == PRESC_MAX);
        w_presc_inc   = w_tick ? '0 : r_presc + 1'b1;
    end

    // Next-state: cancel beats start beats pause beats the one-second tick
    always_comb begin
        logic w_advance;
        w_state_nxt   = r_state;
        w_tens_nxt    = r_tens;
        w_ones_nxt    = r_ones;
        w_presc_nxt   = r_presc;
        w_timeout_nxt = 1'b0;
        w_advance     = 1'b0;

        if (cancel) begin
            w_state_nxt = S_IDLE;
            w_tens_nxt  = 4'd0;
            w_ones_nxt  = 4'd0;
            w_presc_nxt = '0;
        end else if (start) begin
            w_state_nxt = S_RUN;
            w_tens_nxt  = w_preset_tens;
            w_ones_nxt  = w_preset_ones;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_tens_nxt  = 4'd0;
                    w_ones_nxt  = 4'd0;
                    w_presc_nxt = '0;
                end
                S_RUN: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSED;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
                S_PAUSED: begin
                    // Leaving pause counts as a normal run cycle from the frozen prescaler
                    if (!pause) begin
                        w_state_nxt = S_RUN;
                        w_advance   = 1'b1;
                    end
                end
                S_DONE: begin
                    w_presc_nxt = w_presc_inc;
                    if (w_tick) begin
                        w_state_nxt = S_IDLE;
                        w_tens_nxt  = 4'd0;
                        w_ones_nxt  = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        if (w_advance) begin
            w_presc_nxt = w_presc_inc;
            if (w_tick) begin
                if ((r_tens == 4'd0) && (r_ones <= 4'd1)) begin
                    w_tens_nxt    = 4'd0;
                    w_ones_nxt    = 4'd0;
                    w_state_nxt   = S_DONE;
                    w_timeout_nxt = 1'b1;
                end else if (r_ones == 4'd0) begin
                    w_ones_nxt = 4'd9;
                    w_tens_nxt = r_tens - 4'd1;
                end else begin
                    w_ones_nxt = r_ones - 4'd1;
                end
            end
        end
    end

    // State, count, prescaler and registered outputs
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tens    <= 4'd0;
            r_ones    <= 4'd0;
            r_presc   <= '0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tens    <= w_tens_nxt;
            r_ones    <= w_ones_nxt;
            r_presc   <= w_presc_nxt;
            r_timeout <= w_timeout_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    assign seconds = {r_busy, r_tens, r_ones};
    assign timeout = r_timeout;
    assign busy    = r_busy;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - scoreboard bench for countdown_timer_ctrl
module tb_countdown_timer_ctrl;

    localparam int T = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic       clk_out = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] start_bcd = 8'h00;
    logic       cancel = 1'b0;
    logic       pause = 1'b0;
    logic [8:0] seconds;
    logic       timeout;
    logic       busy;

    countdown_timer_ctrl #(.TICKS_PER_SEC(T), .DEFAULT_SECS(8'h30)) dut (
        .clk_out   (clk_out),
        .reset     (reset),
        .start     (start),
        .start_bcd (start_bcd),
        .cancel    (cancel),
        .pause     (pause),
        .seconds   (seconds),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk_out = ~clk_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [10:0] exp_q[$];

    // Reference model: value kept as a plain decimal integer
    int m_mode  = M_IDLE;
    int m_value = 0;
    int m_ph    = 0;
    bit m_to    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_now(input string name, input logic [8:0] s, input logic t, input logic b);
        check(name, {21'd0, seconds, timeout, busy}, {21'd0, s, t, b});
    endtask

    function automatic int preset_of(input logic [7:0] b);
        logic [7:0] r;
        int tn, on;
        r  = (b == 8'h00) ? 8'h30 : b;
        tn = (r[7:4] > 4'd9) ? 9 : int'(r[7:4]);
        on = (r[3:0] > 4'd9) ? 9 : int'(r[3:0]);
        return tn * 10 + on;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_value = 0; m_ph = 0; m_to = 1'b0;
    endtask

    task automatic model_second();
        if (m_ph == T - 1) begin
            m_ph = 0;
            if (m_value <= 1) begin
                m_value = 0; m_mode = M_DONE; m_to = 1'b1;
            end else begin
                m_value = m_value - 1;
            end
        end else begin
            m_ph = m_ph + 1;
        end
    endtask

    task automatic model_step(input bit st, input logic [7:0] bcd, input bit cn, input bit ps);
        m_to = 1'b0;
        if (cn) begin
            m_mode = M_IDLE; m_value = 0; m_ph = 0;
        end else if (st) begin
            m_mode = M_RUN; m_value = preset_of(bcd); m_ph = 0;
        end else begin
            case (m_mode)
                M_RUN:    if (ps) m_mode = M_PAUSED; else model_second();
                M_PAUSED: if (!ps) begin m_mode = M_RUN; model_second(); end
                M_DONE: begin
                    if (m_ph == T - 1) begin m_mode = M_IDLE; m_value = 0; m_ph = 0; end
                    else m_ph = m_ph + 1;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [10:0] model_out();
        logic act;
        act = (m_mode != M_IDLE);
        return {act, 4'(m_value / 10), 4'(m_value % 10), m_to, act};
    endfunction

    task automatic cyc(input bit st, input logic [7:0] bcd, input bit cn, input bit ps);
        @(negedge clk_out);
        start = st; start_bcd = bcd; cancel = cn; pause = ps;
        model_step(st, bcd, cn, ps);
        exp_q.push_back(model_out());
        @(posedge clk_out);
        #2;
    endtask

    // Monitor: every clock the DUT presents a new output word; compare against the queue head
    always begin
        logic [10:0] e;
        @(posedge clk_out);
        #1;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_cycle", {21'd0, seconds, timeout, busy}, {21'd0, e});
        end
    end

    initial begin
        bit ps_lvl;
        #1 reset = 1'b1;
        #11;
        chk_now("reset_state", 9'h000, 1'b0, 1'b0);
        @(negedge clk_out);
        reset = 1'b0;
        model_reset();

        // 1: pause and cancel in IDLE change nothing
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 0);
        chk_now("idle_ignore", 9'h000, 1'b0, 1'b0);

        // 2: countdown from 03
        cyc(1, 8'h03, 0, 0);
        chk_now("t2_load", 9'h103, 1'b0, 1'b1);
        repeat (4) cyc(0, 8'h00, 0, 0);
        chk_now("t2_first_dec", 9'h102, 1'b0, 1'b1);
        repeat (8) cyc(0, 8'h00, 0, 0);
        chk_now("t2_expire", 9'h100, 1'b1, 1'b1);
        cyc(0, 8'h00, 0, 0);
        chk_now("t2_pulse_one", 9'h100, 1'b0, 1'b1);
        repeat (3) cyc(0, 8'h00, 0, 0);
        chk_now("t2_idle", 9'h000, 1'b0, 1'b0);

        // 3: borrow from tens
        cyc(1, 8'h10, 0, 0);
        chk_now("t3_load", 9'h110, 1'b0, 1'b1);
        repeat (4) cyc(0, 8'h00, 0, 0);
        chk_now("t3_borrow", 9'h109, 1'b0, 1'b1);
        repeat (36) cyc(0, 8'h00, 0, 0);
        chk_now("t3_expire", 9'h100, 1'b1, 1'b1);
        repeat (4) cyc(0, 8'h00, 0, 0);

        // 4: pause after two prescaler counts
        cyc(1, 8'h05, 0, 0);
        repeat (2) cyc(0, 8'h00, 0, 0);
        repeat (10) cyc(0, 8'h00, 0, 1);
        chk_now("t4_paused", 9'h105, 1'b0, 1'b1);
        cyc(0, 8'h00, 0, 0);
        chk_now("t4_release1", 9'h105, 1'b0, 1'b1);
        cyc(0, 8'h00, 0, 0);
        chk_now("t4_release2", 9'h104, 1'b0, 1'b1);

        // 5: priority and preset rules
        cyc(1, 8'h07, 1, 0);
        chk_now("t5_cancel_wins", 9'h000, 1'b0, 1'b0);
        cyc(1, 8'h00, 0, 0);
        chk_now("t5_default", 9'h130, 1'b0, 1'b1);
        cyc(1, 8'hA5, 0, 0);
        chk_now("t5_clamp", 9'h195, 1'b0, 1'b1);
        cyc(1, 8'h03, 0, 0);
        repeat (4) cyc(0, 8'h00, 0, 0);
        chk_now("t5_at_102", 9'h102, 1'b0, 1'b1);
        repeat (2) cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h03, 0, 0);
        repeat (3) cyc(0, 8'h00, 0, 0);
        chk_now("t5_reload_hold", 9'h103, 1'b0, 1'b1);
        cyc(0, 8'h00, 0, 0);
        chk_now("t5_reload_dec", 9'h102, 1'b0, 1'b1);

        // 6: asynchronous reset mid-run
        cyc(1, 8'h07, 0, 0);
        chk_now("t6_load", 9'h107, 1'b0, 1'b1);
        cyc(0, 8'h00, 0, 0);
        @(negedge clk_out);
        start = 1'b0; cancel = 1'b0; pause = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_now("t6_async_reset", 9'h000, 1'b0, 1'b0);
        exp_q.delete();
        @(negedge clk_out);
        chk_now("t6_reset_hold", 9'h000, 1'b0, 1'b0);
        reset = 1'b0;
        model_reset();
        repeat (40) cyc(0, 8'h00, 0, 0);

        // Randomized traffic against the model
        ps_lvl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            bit st, cn;
            logic [7:0] bcd;
            int sel;
            st = ($urandom_range(0, 59) == 0);
            cn = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 5) == 0) ps_lvl = ~ps_lvl;
            sel = $urandom_range(0, 3);
            if (sel == 0)      bcd = 8'h00;
            else if (sel == 1) bcd = 8'($urandom_range(0, 255));
            else               bcd = {4'h0, 4'($urandom_range(0, 15))};
            cyc(st, bcd, cn, ps_lvl);
        end
        cyc(0, 8'h00, 1, 0);
        @(posedge clk_out);
        #3;
        check("sb_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
